// File: rtl/sprite_mover.sv
// sprite_mover
//
// Frame-rate movement controller for maze sprites (player or ghost). Each
// rising edge of frame_clk advances the sprite one step along its current
// direction, stops it at walls or the playfield bounds, wraps it through
// tunnel rows, and applies direction requests from the keyboard or ghost AI.
// Perpendicular turns are only accepted when the sprite is centred in its
// tile on the axis it is currently travelling.
//
// Optional feature macro: SPRITE_MOVER_TURN_BUFFER_EN
//   When defined, a request that cannot be honoured yet is held as a pending
//   turn for up to PEND_FRAMES frames and applied as soon as it becomes
//   legal. When undefined, such requests are dropped and PendValid is 0.
//
// Ports:
//   frame_clk   in   frame clock, one update per rising edge
//   Reset       in   asynchronous active-high reset
//   keycode     in   8-bit request: 0x04 left, 0x07 right, 0x16 down, 0x1A up
//   UpWall      in   wall in the adjacent tile above
//   DownWall    in   wall in the adjacent tile below
//   LeftWall    in   wall in the adjacent tile to the left
//   RightWall   in   wall in the adjacent tile to the right
//   PosX, PosY  out  sprite centre coordinates
//   Dir         out  direction: 0 right, 1 left, 2 up, 3 down
//   Moving      out  sprite is in motion
//   Wrapped     out  one-frame pulse after a tunnel wrap
//   PendValid   out  a buffered turn is held

module sprite_mover #(
  parameter int          COORD_W       = 10,
  parameter int          TILE_LOG2     = 4,
  parameter int          ALIGN_OFS     = 7,
  parameter int          STEP          = 1,
  parameter int          SIZE          = 8,
  parameter int          X_MIN         = 32,
  parameter int          X_MAX         = 431,
  parameter int          Y_MIN         = 64,
  parameter int          Y_MAX         = 447,
  parameter int          START_X       = 231,
  parameter int          START_Y       = 312,
  parameter logic [63:0] TUNNEL_ROWS   = 64'h0000_0000_0004_A000,
  parameter int          TUNNEL_L_TILE = 2,
  parameter int          TUNNEL_R_TILE = 26,
  parameter int          TUNNEL_L_X    = 42,
  parameter int          TUNNEL_R_X    = 412,
  parameter int          PEND_FRAMES   = 16
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic               UpWall,
  input  logic               DownWall,
  input  logic               LeftWall,
  input  logic               RightWall,
  output logic [COORD_W-1:0] PosX,
  output logic [COORD_W-1:0] PosY,
  output logic [1:0]         Dir,
  output logic               Moving,
  output logic               Wrapped,
  output logic               PendValid
);

  localparam int ROW_W = COORD_W - TILE_LOG2;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  // One extra bit so that the bounds checks can never overflow or underflow.
  localparam logic [COORD_W:0] X_LO_LIM = (COORD_W+1)'(X_MIN + SIZE + STEP);
  localparam logic [COORD_W:0] X_HI_LIM = (COORD_W+1)'(X_MAX - SIZE);
  localparam logic [COORD_W:0] Y_LO_LIM = (COORD_W+1)'(Y_MIN + SIZE + STEP);
  localparam logic [COORD_W:0] Y_HI_LIM = (COORD_W+1)'(Y_MAX - SIZE);
  localparam logic [COORD_W:0] STEP_EXT = (COORD_W+1)'(STEP);

  localparam logic [COORD_W-1:0]   STEP_C    = COORD_W'(STEP);
  localparam logic [COORD_W-1:0]   START_X_C = COORD_W'(START_X);
  localparam logic [COORD_W-1:0]   START_Y_C = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0]   L_LAND_X  = COORD_W'(TUNNEL_L_X);
  localparam logic [COORD_W-1:0]   R_LAND_X  = COORD_W'(TUNNEL_R_X);
  localparam logic [ROW_W-1:0]     L_TILE    = ROW_W'(TUNNEL_L_TILE);
  localparam logic [ROW_W-1:0]     R_TILE    = ROW_W'(TUNNEL_R_TILE);
  localparam logic [TILE_LOG2-1:0] ALIGN_C   = TILE_LOG2'(ALIGN_OFS);

  logic [3:0]         wall;
  logic [3:0]         legal;
  logic               x_aligned;
  logic               y_aligned;
  logic               axis_aligned;
  logic [ROW_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               tunnel_row;
  logic               can_step;
  logic               req_valid;
  logic [1:0]         req_dir;

  logic [COORD_W-1:0] pos_x_n;
  logic [COORD_W-1:0] pos_y_n;
  logic [1:0]         dir_n;
  logic               moving_n;
  logic               wrapped_n;

  // Wall inputs gathered into a vector indexed by the direction code.
  assign wall = {DownWall, UpWall, LeftWall, RightWall};

  assign x_aligned    = (PosX[TILE_LOG2-1:0] == ALIGN_C);
  assign y_aligned    = (PosY[TILE_LOG2-1:0] == ALIGN_C);
  assign axis_aligned = Dir[1] ? y_aligned : x_aligned;

  assign col        = PosX[COORD_W-1:TILE_LOG2];
  assign row        = PosY[COORD_W-1:TILE_LOG2];
  assign tunnel_row = |(TUNNEL_ROWS & (64'd1 << row));

  // Keycode decode into a direction request.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    case (keycode)
      8'h04:   req_dir = DIR_LEFT;
      8'h07:   req_dir = DIR_RIGHT;
      8'h16:   req_dir = DIR_DOWN;
      8'h1A:   req_dir = DIR_UP;
      default: req_valid = 1'b0;
    endcase
  end

  // Direction d is legal when its wall is clear and it either stays on the
  // current axis (continue or reverse) or the sprite is centred on that axis.
  // Direction codes 2 and 3 are the vertical ones, so bit 1 names the axis.
  always_comb begin
    legal = '0;
    for (int i = 0; i < 4; i++) begin
      legal[i] = !wall[i] && (((i >= 2) == Dir[1]) || axis_aligned);
    end
  end

  // Whether one more step along the registered direction stays in bounds.
  always_comb begin
    can_step = 1'b0;
    case (Dir)
      DIR_RIGHT: can_step = ({1'b0, PosX} + STEP_EXT) <= X_HI_LIM;
      DIR_LEFT:  can_step = {1'b0, PosX} >= X_LO_LIM;
      DIR_UP:    can_step = {1'b0, PosY} >= Y_LO_LIM;
      default:   can_step = ({1'b0, PosY} + STEP_EXT) <= Y_HI_LIM;
    endcase
  end

`ifdef SPRITE_MOVER_TURN_BUFFER_EN
  localparam int             CNT_W   = $clog2(PEND_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PEND_FRAMES);

  logic [1:0]       pend_dir;
  logic [CNT_W-1:0] pend_cnt;
  logic [1:0]       pend_dir_n;
  logic [CNT_W-1:0] pend_cnt_n;
  logic             pend_valid_n;
`endif

  // Next-state: tunnel wrap first, otherwise advance or stop; the request
  // stage then overrides Dir/Moving, so a stop against the old direction and
  // a new legal request in the same frame leave the sprite moving the new way.
  always_comb begin
    pos_x_n   = PosX;
    pos_y_n   = PosY;
    dir_n     = Dir;
    moving_n  = Moving;
    wrapped_n = 1'b0;
`ifdef SPRITE_MOVER_TURN_BUFFER_EN
    pend_valid_n = PendValid;
    pend_dir_n   = pend_dir;
    pend_cnt_n   = pend_cnt;
`endif

    if (Moving && Dir == DIR_RIGHT && col == R_TILE && tunnel_row) begin
      pos_x_n   = L_LAND_X;
      wrapped_n = 1'b1;
    end else if (Moving && Dir == DIR_LEFT && col == L_TILE && tunnel_row) begin
      pos_x_n   = R_LAND_X;
      wrapped_n = 1'b1;
    end else if (Moving) begin
      if (!wall[Dir] && can_step) begin
        case (Dir)
          DIR_RIGHT: pos_x_n = PosX + STEP_C;
          DIR_LEFT:  pos_x_n = PosX - STEP_C;
          DIR_UP:    pos_y_n = PosY - STEP_C;
          default:   pos_y_n = PosY + STEP_C;
        endcase
      end else begin
        moving_n = 1'b0;
      end
    end

    if (req_valid && legal[req_dir]) begin
      dir_n    = req_dir;
      moving_n = 1'b1;
`ifdef SPRITE_MOVER_TURN_BUFFER_EN
      pend_valid_n = 1'b0;
      pend_cnt_n   = '0;
    end else if (req_valid) begin
      // A newer blocked request always replaces an older one.
      pend_valid_n = 1'b1;
      pend_dir_n   = req_dir;
      pend_cnt_n   = CNT_LOAD;
    end else if (PendValid && legal[pend_dir]) begin
      dir_n        = pend_dir;
      moving_n     = 1'b1;
      pend_valid_n = 1'b0;
      pend_cnt_n   = '0;
    end else if (PendValid) begin
      pend_cnt_n = pend_cnt - 1'b1;
      if (pend_cnt <= CNT_W'(1)) begin
        pend_valid_n = 1'b0;
      end
`endif
    end
  end

  // State register; every output comes straight from a flop.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      PosX    <= START_X_C;
      PosY    <= START_Y_C;
      Dir     <= DIR_RIGHT;
      Moving  <= 1'b0;
      Wrapped <= 1'b0;
    end else begin
      PosX    <= pos_x_n;
      PosY    <= pos_y_n;
      Dir     <= dir_n;
      Moving  <= moving_n;
      Wrapped <= wrapped_n;
    end
  end

`ifdef SPRITE_MOVER_TURN_BUFFER_EN
  // Buffered-turn register.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      PendValid <= 1'b0;
      pend_dir  <= DIR_RIGHT;
      pend_cnt  <= '0;
    end else begin
      PendValid <= pend_valid_n;
      pend_dir  <= pend_dir_n;
      pend_cnt  <= pend_cnt_n;
    end
  end
`else
  assign PendValid = 1'b0;
`endif

endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised frame-rate movement controller for maze sprites (player and ghosts) that generalises the single-player mover. It converts a keycode or AI direction code plus four wall-probe inputs into a registered sprite position, direction and motion state. It adds configurable speed, tile geometry, bounds and tunnel rows, tile-aligned cornering, and an optional buffered-turn queue. It sits between the keyboard or ghost-AI front end and the maze wall lookup and sprite renderer.

## Interface
- COORD_W, 10, coordinate width in bits
- TILE_LOG2, 4, log2 of the tile size in pixels
- ALIGN_OFS, 7, in-tile offset at which a sprite counts as tile-centred
- STEP, 1, pixels moved per frame (1..2^TILE_LOG2-1)
- SIZE, 8, sprite half-size
- X_MIN / X_MAX / Y_MIN / Y_MAX, 32 / 431 / 64 / 447, playfield bounds
- START_X / START_Y, 231 / 312, reset position
- TUNNEL_ROWS, 64'h0000_0000_0004_A000, bitmask of tile rows (rows 13, 15, 18) that contain wrap tunnels
- TUNNEL_L_TILE / TUNNEL_R_TILE, 2 / 26, tile columns that trigger a wrap
- TUNNEL_L_X / TUNNEL_R_X, 42 / 412, landing X for a rightward wrap / a leftward wrap
- PEND_FRAMES, 16, lifetime of a buffered turn in frames
- frame_clk  in  1  frame clock; one update per rising edge
- Reset  in  1  asynchronous, active-high reset
- keycode  in  8  direction request: 0x04 left, 0x07 right, 0x16 down, 0x1A up; any other value is "no request"
- UpWall, DownWall, LeftWall, RightWall  in  1 each  wall present in the adjacent tile in that direction, valid at the edge
- PosX, PosY  out  COORD_W each  sprite centre
- Dir  out  2  direction: 0 right, 1 left, 2 up, 3 down
- Moving  out  1  sprite is in motion
- Wrapped  out  1  one-frame pulse on a tunnel wrap
- PendValid  out  1  a buffered turn is held

## Operation
- Aligned: X axis when PosX[TILE_LOG2-1:0]==ALIGN_OFS; Y axis likewise. Tile column/row = Pos>>TILE_LOG2.
- A requested direction d is legal when wall[d]==0 and one of these holds:
  - d is on the current axis (same direction or reversal), or
  - d is perpendicular and the current-axis coordinate is aligned.
- Each edge is evaluated in this priority order:
  1. Tunnel: Moving, Dir=right, column==TUNNEL_R_TILE, row bit set in TUNNEL_ROWS → PosX<=TUNNEL_L_X, Wrapped<=1. The leftward case lands on TUNNEL_R_X. PosY is unchanged and motion continues.
  2. Advance:
     - If Moving and wall[Dir]==0 and the stepped coordinate stays within [MIN+SIZE, MAX-SIZE] → position += or -= STEP.
     - If Moving and not advanced → Moving<=0; Dir is held.
  3. Request:
     - Legal keycode request → Dir<=d, Moving<=1, pending cleared.
     - Illegal keycode request → stored as pending (overwrites any older pending entry), and the lifetime counter reloads to PEND_FRAMES.
     - No request and pending legal → pending applied and cleared.
     - Otherwise the pending counter decrements; pending clears when it reaches 0.
- A request updates Dir and Moving in the same edge as the advance step. The advance step uses the Dir value registered before that edge.
- Coordinate arithmetic is unsigned COORD_W and never wraps, because the bounds check precedes the update.

## Timing
- Reset values: PosX=START_X, PosY=START_Y, Dir=0, Moving=0, Wrapped=0, PendValid=0, pending counter=0.
- All outputs are registered.
- Keycode sampled at edge N → Dir/Moving valid after N. First position change occurs at edge N+1.
- Wrapped is high for exactly the one frame following the wrap edge.
- Reset asserted mid-motion or mid-pending clears all state immediately. The first update after release uses reset values.
- A request and a wall stop in the same edge: the stop applies to the old Dir, and the new Dir and Moving then take effect.

## Configuration
- SPRITE_MOVER_TURN_BUFFER_EN defined: pending queue, PendValid and the PEND_FRAMES counter behave as described above.
- Not defined: illegal requests are discarded, PendValid is tied to 0, and no counter is built.

## Test plan
- Reset release, keycode 0x07, no walls → Dir=0, Moving=1 after edge 1; PosX=232 after edge 2; PosX=236 after edge 6.
- Moving right with RightWall=1 from PosX=240 → PosX holds at 240 and Moving=0 one edge later; Dir stays 0.
- Moving right at PosX=236 (unaligned), keycode 0x1A for one frame (buffer enabled) → PendValid=1. At PosX=247 (aligned) with UpWall=0 → Dir=2, PendValid=0, then PosY decrements. With the buffer disabled, the request is dropped.
- Illegal request with no alignment reached for 16 frames → PendValid falls to 0 at frame 16.
- Moving right, PosY=246 (row 15), PosX reaches column 26 → PosX=42, Wrapped=1 for one frame. Mirror case moving left → PosX=412.
- Reset asserted while Moving=1 and PendValid=1 → all outputs at reset values without waiting for a clock edge.
